// File: rtl/kan_os_systolic_array_if.sv
// Operand/result stream bundle for kan_os_systolic_array (master = host side, slave = array).
// Ports: start/k_len/acc_mode run request; a_data/b_data/in_valid/in_ready operand beat channel;
// out_data/out_row/out_last/out_valid/out_ready result row channel; busy/done/cfg_err status.
interface kan_os_systolic_array_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_MAX      = 256
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                       start;
  logic [KW-1:0]              k_len;
  logic                       acc_mode;
  logic [ROWS*DATA_WIDTH-1:0] a_data;
  logic [COLS*DATA_WIDTH-1:0] b_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [COLS*ACC_WIDTH-1:0]  out_data;
  logic [RW-1:0]              out_row;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  modport master (
    output start, k_len, acc_mode, a_data, b_data, in_valid, out_ready,
    input  in_ready, out_data, out_row, out_valid, out_last, busy, done, cfg_err
  );

  modport slave (
    input  start, k_len, acc_mode, a_data, b_data, in_valid, out_ready,
    output in_ready, out_data, out_row, out_valid, out_last, busy, done, cfg_err
  );
endinterface

// File: rtl/kan_os_systolic_array.sv
// Output-stationary ROWSxCOLS systolic matmul C = A*B with run-time depth k_len and internal input skew.
// Latency: last operand beat at edge t -> first result row valid in cycle t+ROWS+COLS; one row per beat.
// Backpressure: in_ready from registered state only; result rows hold stable while out_ready is low.
// Ports: clk, rst (sync, active high); io = operand channel, result channel and run status.
module kan_os_systolic_array #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_MAX      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  kan_os_systolic_array_if.slave    io
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_cnt_q, beat_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic in_ready, beat_acc, start_ok, clear_acc;

  assign in_ready  = (state_q == LOAD) && (beat_cnt_q < k_len_q);
  assign beat_acc  = io.in_valid && in_ready;
  assign start_ok  = (io.k_len != '0) && (io.k_len <= KW'(K_MAX));
  // Accumulators clear on the accepting start edge, so the first MAC of the run sees zero.
  assign clear_acc = (state_q == IDLE) && io.start && start_ok && !io.acc_mode;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          if (start_ok) begin
            state_d    = LOAD;
            k_len_d    = io.k_len;
            beat_cnt_d = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_q + KW'(1) == k_len_q) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        // ROWS+COLS-1 cycles lets the last beat reach PE(ROWS-1,COLS-1) through the skew.
        if (flush_cnt_q == FW'(ROWS + COLS - 2)) begin
          state_d = DRAIN;
          row_d   = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      DRAIN: begin
        if (io.out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Operand presented to each PE: {valid, data}. Column 0 / row 0 come from the skew
  // lines, the rest from the neighbour's pipeline register.
  logic [DW-1:0] pe_a_dat [ROWS][COLS];
  logic          pe_a_vld [ROWS][COLS];
  logic [DW-1:0] pe_b_dat [ROWS][COLS];
  logic          pe_b_vld [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign pe_a_vld[0][0] = beat_acc;
      assign pe_a_dat[0][0] = io.a_data[0 +: DW];
    end else begin : g_delay
      logic [DW:0] sk_q [r];
      logic [DW:0] sk_d [r];
      always_comb begin
        sk_d[0] = {beat_acc, io.a_data[r*DW +: DW]};
        for (int i = 1; i < r; i++) sk_d[i] = sk_q[i-1];
      end
      always_ff @(posedge clk) begin
        for (int i = 0; i < r; i++) sk_q[i] <= rst ? '0 : sk_d[i];
      end
      assign {pe_a_vld[r][0], pe_a_dat[r][0]} = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign pe_b_vld[0][0] = beat_acc;
      assign pe_b_dat[0][0] = io.b_data[0 +: DW];
    end else begin : g_delay
      logic [DW:0] sk_q [c];
      logic [DW:0] sk_d [c];
      always_comb begin
        sk_d[0] = {beat_acc, io.b_data[c*DW +: DW]};
        for (int i = 1; i < c; i++) sk_d[i] = sk_q[i-1];
      end
      always_ff @(posedge clk) begin
        for (int i = 0; i < c; i++) sk_q[i] <= rst ? '0 : sk_d[i];
      end
      assign {pe_b_vld[0][c], pe_b_dat[0][c]} = sk_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c < COLS - 1) begin : g_east
        logic [DW:0] a_q, a_d;
        assign a_d = {pe_a_vld[r][c], pe_a_dat[r][c]};
        always_ff @(posedge clk) a_q <= rst ? '0 : a_d;
        assign {pe_a_vld[r][c+1], pe_a_dat[r][c+1]} = a_q;
      end
      if (r < ROWS - 1) begin : g_south
        logic [DW:0] b_q, b_d;
        assign b_d = {pe_b_vld[r][c], pe_b_dat[r][c]};
        always_ff @(posedge clk) b_q <= rst ? '0 : b_d;
        assign {pe_b_vld[r+1][c], pe_b_dat[r+1][c]} = b_q;
      end
    end
  end

  logic [AW-1:0]          acc_q [ROWS][COLS];
  logic [AW-1:0]          acc_d [ROWS][COLS];
  logic signed [2*DW-1:0] prod;

  // Full-precision signed product, sign-extended and summed modulo 2^AW.
  always_comb begin
    prod = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod = (2*DW)'($signed(pe_a_dat[r][c])) * (2*DW)'($signed(pe_b_dat[r][c]));
        acc_d[r][c] = acc_q[r][c];
        if (clear_acc) acc_d[r][c] = '0;
        else if (pe_a_vld[r][c] && pe_b_vld[r][c]) acc_d[r][c] = acc_q[r][c] + AW'(prod);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) acc_q[r][c] <= rst ? '0 : acc_d[r][c];
    end
  end

  logic [COLS*AW-1:0] out_data;
  always_comb begin
    out_data = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) out_data[c*AW +: AW] = acc_q[row_q][c];
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_data  = out_data;
  assign io.out_row   = row_q;
  assign io.out_valid = (state_q == DRAIN);
  assign io.out_last  = (state_q == DRAIN) && (row_q == RW'(ROWS - 1));
  assign io.busy      = (state_q != IDLE);
  assign io.done      = done_q;
  assign io.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_kan_os_systolic_array.sv
module tb_kan_os_systolic_array;
  localparam int ROWS = 4, COLS = 4, DW = 16, AW = 40, K_MAX = 256, KT = 16;
  localparam int KW = $clog2(K_MAX + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kan_os_systolic_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(K_MAX)) io();
  kan_os_systolic_array #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(K_MAX))
    dut (.clk(clk), .rst(rst), .io(io));

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic signed [DW-1:0] mat_a [ROWS][KT];
  logic signed [DW-1:0] mat_b [KT][COLS];
  logic [AW-1:0] model_acc [ROWS][COLS];
  logic [AW-1:0] got_dat [ROWS][COLS];
  logic [1:0]    got_row [ROWS];
  bit            got_last [ROWS];
  int lat;
  bit run_ok, stall_stable, done_seen, cfg_seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: C = A*B over k terms (matrix arithmetic), optionally added onto prior results, mod 2^AW.
  task automatic model_run(input int k, input bit accm);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        longint p;
        if (!accm) model_acc[r][c] = '0;
        for (int kk = 0; kk < k; kk++) begin
          p = longint'(mat_a[r][kk]) * longint'(mat_b[kk][c]);
          model_acc[r][c] = model_acc[r][c] + AW'(p);
        end
      end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model_acc[r][c] = '0;
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < ROWS; r++) mat_a[r][kk] = DW'($urandom);
      for (int c = 0; c < COLS; c++) mat_b[kk][c] = DW'($urandom);
    end
  endtask

  task automatic fill_identity();
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < ROWS; r++) mat_a[r][kk] = (r == kk) ? 16'sd1 : 16'sd0;
      for (int c = 0; c < COLS; c++) mat_b[kk][c] = DW'(4 * kk + c + 1);
    end
  endtask

  task automatic do_start(input int k, input bit accm);
    io.start = 1'b1; io.k_len = KW'(k); io.acc_mode = accm;
    step();
    io.start = 1'b0;
  endtask

  // Presents k beats (optionally with in_valid toggling), optionally pokes a bogus start
  // at beat poke_at, then counts cycles from the last accepted beat to out_valid.
  task automatic load_beats(input int k, input bit gap, input int poke_at);
    int kk = 0, cyc = 0;
    bit tog = 1'b1, take;
    run_ok = 1'b1; cfg_seen = 1'b0;
    while (kk < k && cyc < 4 * k + 50) begin
      io.in_valid = gap ? tog : 1'b1;
      tog = !tog;
      for (int r = 0; r < ROWS; r++) io.a_data[r*DW +: DW] = mat_a[r][kk];
      for (int c = 0; c < COLS; c++) io.b_data[c*DW +: DW] = mat_b[kk][c];
      io.start = (kk == poke_at);
      if (kk == poke_at) io.k_len = '0;
      take = io.in_valid && io.in_ready;
      step();
      cyc++;
      if (io.cfg_err) cfg_seen = 1'b1;
      if (take) kk++;
    end
    io.in_valid = 1'b0; io.start = 1'b0;
    if (kk < k) run_ok = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic drain_rows(input int stall_row, input int stall_len);
    int n = 0, cyc = 0, left = stall_len;
    logic [COLS*AW-1:0] snap_d;
    logic [1:0] snap_r;
    logic snap_l;
    bit snapped = 1'b0;
    stall_stable = 1'b1;
    while (n < ROWS && cyc < 200) begin
      if (io.out_valid) begin
        if (snapped && n == stall_row &&
            (io.out_data !== snap_d || io.out_row !== snap_r || io.out_last !== snap_l))
          stall_stable = 1'b0;
        if (n == stall_row && left > 0) begin
          io.out_ready = 1'b0;
          if (!snapped) begin
            snap_d = io.out_data; snap_r = io.out_row; snap_l = io.out_last; snapped = 1'b1;
          end
          left--;
        end else begin
          io.out_ready = 1'b1;
          for (int c = 0; c < COLS; c++) got_dat[n][c] = io.out_data[c*AW +: AW];
          got_row[n] = io.out_row;
          got_last[n] = io.out_last;
          n++;
        end
      end else begin
        io.out_ready = 1'b0;
      end
      step();
      cyc++;
    end
    io.out_ready = 1'b0;
    if (n < ROWS) run_ok = 1'b0;
    done_seen = io.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_cnt++;
    if ({io.busy, io.in_ready, io.out_valid, io.out_last, io.done, io.cfg_err} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000",
               {io.busy, io.in_ready, io.out_valid, io.out_last, io.done, io.cfg_err});
    else pass_cnt++;
    chk_cnt++;
    if (io.out_data !== '0) $display("FAIL reset_out_data: got %h required 0", io.out_data);
    else pass_cnt++;
    chk_cnt++;
    if (io.out_row !== 2'd0) $display("FAIL reset_out_row: got %0d required 0", io.out_row);
    else pass_cnt++;
  endtask

  task automatic test_identity();
    fill_identity();
    do_start(4, 1'b0);
    chk_cnt++;
    if (io.busy !== 1'b1 || io.in_ready !== 1'b1)
      $display("FAIL ident_start: busy=%b in_ready=%b required 1 1", io.busy, io.in_ready);
    else pass_cnt++;
    load_beats(4, 1'b0, -1);
    drain_rows(-1, 0);
    model_run(4, 1'b0);
    chk_cnt++;
    if (run_ok !== 1'b1) $display("FAIL ident_complete: run_ok=%b required 1", run_ok);
    else pass_cnt++;
    chk_cnt++;
    if (lat != ROWS + COLS) $display("FAIL ident_latency: got %0d required %0d", lat, ROWS + COLS);
    else pass_cnt++;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        chk_cnt++;
        if (got_dat[r][c] !== AW'(4 * r + c + 1))
          $display("FAIL ident_c[%0d][%0d]: got %h required %h", r, c, got_dat[r][c], AW'(4 * r + c + 1));
        else pass_cnt++;
      end
      chk_cnt++;
      if (got_last[r] !== (r == ROWS - 1) || got_row[r] !== 2'(r))
        $display("FAIL ident_row%0d_tag: last=%b row=%0d required last=%b row=%0d",
                 r, got_last[r], got_row[r], (r == ROWS - 1), r);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_seen !== 1'b1) $display("FAIL ident_done: got %b required 1", done_seen);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (io.done !== 1'b0 || io.busy !== 1'b0)
      $display("FAIL ident_done_pulse: done=%b busy=%b required 0 0", io.done, io.busy);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    logic [AW-1:0] lit;
    bit modes [3] = '{1'b0, 1'b1, 1'b0};
    for (int r = 0; r < ROWS; r++) mat_a[r][0] = -16'sd3;
    for (int c = 0; c < COLS; c++) mat_b[0][c] = 16'sd5;
    for (int i = 0; i < 3; i++) begin
      do_start(1, modes[i]);
      load_beats(1, 1'b0, -1);
      drain_rows(-1, 0);
      model_run(1, modes[i]);
      lit = (i == 1) ? 40'hFF_FFFF_FFE2 : 40'hFF_FFFF_FFF1;
      chk_cnt++;
      if (got_dat[0][0] !== lit) $display("FAIL signed_lit%0d: got %h required %h", i, got_dat[0][0], lit);
      else pass_cnt++;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          chk_cnt++;
          if (got_dat[r][c] !== model_acc[r][c])
            $display("FAIL signed%0d_c[%0d][%0d]: got %h required %h", i, r, c, got_dat[r][c], model_acc[r][c]);
          else pass_cnt++;
        end
    end
  endtask

  task automatic test_backpressure();
    fill_identity();
    do_start(4, 1'b0);
    load_beats(4, 1'b1, -1);
    drain_rows(1, 3);
    model_run(4, 1'b0);
    chk_cnt++;
    if (run_ok !== 1'b1 || lat != ROWS + COLS)
      $display("FAIL bp_run: run_ok=%b latency=%0d required 1 %0d", run_ok, lat, ROWS + COLS);
    else pass_cnt++;
    chk_cnt++;
    if (stall_stable !== 1'b1) $display("FAIL bp_stall_stable: got %b required 1", stall_stable);
    else pass_cnt++;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        chk_cnt++;
        if (got_dat[r][c] !== AW'(4 * r + c + 1))
          $display("FAIL bp_c[%0d][%0d]: got %h required %h", r, c, got_dat[r][c], AW'(4 * r + c + 1));
        else pass_cnt++;
      end
  endtask

  task automatic test_extremes();
    for (int kk = 0; kk < 2; kk++) begin
      for (int r = 0; r < ROWS; r++) mat_a[r][kk] = 16'sh8000;
      for (int c = 0; c < COLS; c++) mat_b[kk][c] = 16'sh8000;
    end
    do_start(2, 1'b0);
    load_beats(2, 1'b0, -1);
    drain_rows(-1, 0);
    model_run(2, 1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        chk_cnt++;
        if (got_dat[r][c] !== 40'h00_8000_0000)
          $display("FAIL extreme_c[%0d][%0d]: got %h required 0080000000", r, c, got_dat[r][c]);
        else pass_cnt++;
      end
  endtask

  task automatic test_cfg_err();
    int bad [2] = '{0, 257};
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i], 1'b0);
      chk_cnt++;
      if (io.cfg_err !== 1'b1 || io.busy !== 1'b0)
        $display("FAIL cfg_err_k%0d: cfg_err=%b busy=%b required 1 0", bad[i], io.cfg_err, io.busy);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (io.cfg_err !== 1'b0 || io.busy !== 1'b0)
        $display("FAIL cfg_err_pulse_k%0d: cfg_err=%b busy=%b required 0 0", bad[i], io.cfg_err, io.busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_during_load();
    fill_random(6);
    do_start(6, 1'b0);
    load_beats(6, 1'b1, 2);
    drain_rows(-1, 0);
    model_run(6, 1'b0);
    chk_cnt++;
    if (run_ok !== 1'b1 || cfg_seen !== 1'b0 || lat != ROWS + COLS)
      $display("FAIL busy_start: run_ok=%b cfg_err_seen=%b latency=%0d required 1 0 %0d",
               run_ok, cfg_seen, lat, ROWS + COLS);
    else pass_cnt++;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        chk_cnt++;
        if (got_dat[r][c] !== model_acc[r][c])
          $display("FAIL busy_start_c[%0d][%0d]: got %h required %h", r, c, got_dat[r][c], model_acc[r][c]);
        else pass_cnt++;
      end
  endtask

  task automatic test_reset_mid_drain();
    fill_random(5);
    do_start(5, 1'b0);
    load_beats(5, 1'b0, -1);
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_clear();
    chk_cnt++;
    if (io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.in_ready !== 1'b0)
      $display("FAIL rst_drain: out_valid=%b busy=%b in_ready=%b required 0 0 0",
               io.out_valid, io.busy, io.in_ready);
    else pass_cnt++;
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < ROWS; r++) mat_a[r][kk] = (r == kk) ? 16'sd1 : 16'sd0;
      for (int c = 0; c < COLS; c++) mat_b[kk][c] = (c == kk) ? 16'sd1 : 16'sd0;
    end
    do_start(4, 1'b1);
    load_beats(4, 1'b0, -1);
    drain_rows(-1, 0);
    model_run(4, 1'b1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        chk_cnt++;
        if (got_dat[r][c] !== ((r == c) ? 40'd1 : 40'd0))
          $display("FAIL rst_ident_c[%0d][%0d]: got %h required %0d", r, c, got_dat[r][c], (r == c));
        else pass_cnt++;
      end
  endtask

  // Each run starts in the cycle done is high, exercising immediate restart.
  task automatic test_back_to_back();
    for (int run = 0; run < 6; run++) begin
      int k = $urandom_range(1, KT);
      bit accm = 1'($urandom);
      bit gap = 1'($urandom);
      int srow = $urandom_range(0, ROWS - 1);
      int slen = $urandom_range(0, 3);
      fill_random(k);
      do_start(k, accm);
      load_beats(k, gap, -1);
      drain_rows(srow, slen);
      model_run(k, accm);
      chk_cnt++;
      if (run_ok !== 1'b1 || lat != ROWS + COLS || stall_stable !== 1'b1 || done_seen !== 1'b1)
        $display("FAIL b2b%0d_ctrl: run_ok=%b latency=%0d stable=%b done=%b required 1 %0d 1 1",
                 run, run_ok, lat, stall_stable, done_seen, ROWS + COLS);
      else pass_cnt++;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          chk_cnt++;
          if (got_dat[r][c] !== model_acc[r][c])
            $display("FAIL b2b%0d_c[%0d][%0d]: got %h required %h", run, r, c, got_dat[r][c], model_acc[r][c]);
          else pass_cnt++;
        end
    end
  endtask

  initial begin
    rst = 1'b1;
    io.start = 1'b0; io.k_len = '0; io.acc_mode = 1'b0;
    io.a_data = '0; io.b_data = '0; io.in_valid = 1'b0; io.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_identity();
    test_signed();
    test_backpressure();
    test_extremes();
    test_cfg_err();
    test_start_during_load();
    test_reset_mid_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/kan_os_systolic_array.md
# kan_os_systolic_array

Parametrised output-stationary systolic matrix-multiply engine for the KAN datapath. It computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS] for a run-time K, with the input skew generated internally. Operands stream in one K-slice per valid/ready beat, and results drain one row per beat over a second valid/ready channel. It is the successor to the fixed 8×8 array: the grid is rectangular, the reduction depth is configurable, accumulation can optionally continue across runs, and both streams have full backpressure.

## Interface
- ROWS, 4, PE grid rows (≥1)
- COLS, 4, PE grid columns (≥1)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 40, signed accumulator width (≥2·DATA_WIDTH)
- K_MAX, 256, largest legal k_len; KW = $clog2(K_MAX+1)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle run request, sampled only in IDLE
- k_len  in  KW  reduction depth, sampled with start
- acc_mode  in  1  sampled with start; 1 = keep accumulators, 0 = clear
- a_data  in  ROWS·DATA_WIDTH  lane r = A[r][k]
- b_data  in  COLS·DATA_WIDTH  lane c = B[k][c]
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- out_data  out  COLS·ACC_WIDTH  lane c = C[out_row][c]
- out_row  out  max(1,$clog2(ROWS))  row index of the current beat
- out_valid  out  1  result beat valid
- out_ready  in  1  result beat consumed when out_valid & out_ready
- out_last  out  1  high with row ROWS-1
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after the last row is consumed
- cfg_err  out  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start with 1 ≤ k_len ≤ K_MAX → LOAD. Latch k_len. Clear all accumulators unless acc_mode=1.
  - start with k_len=0 or k_len>K_MAX → cfg_err pulse; remain in IDLE.
- LOAD:
  - in_ready=1 while beats_accepted < k_len. in_ready depends only on registered state, never on in_valid.
  - When the k_len-th beat is accepted → FLUSH.
- Skew and propagation:
  - Row r of A is delayed r cycles; column c of B is delayed c cycles.
  - A operands move east one PE per cycle, B operands move south one PE per cycle, each tagged with a valid bit.
  - In a cycle with no accepted beat, bubbles (valid=0) propagate and the PEs do not MAC.
- PE(r,c) does acc += sext(a)·sext(b) when both of its operand valids are set.
  - Product width is 2·DATA_WIDTH, sign-extended to ACC_WIDTH.
  - Sum wraps modulo 2^ACC_WIDTH with no saturation.
- FLUSH: lasts exactly ROWS+COLS-1 cycles (counter), then → DRAIN with row index 0.
- DRAIN:
  - out_valid=1 and out_data = accumulators of out_row.
  - On a handshake the row increments. The handshake on row ROWS-1 → IDLE with a done pulse in the following cycle.
- A start outside IDLE is ignored: no cfg_err, no state change.
- Accumulators are not cleared after DRAIN; this supports the acc_mode=1 chaining.

## Timing
- Reset, effective the cycle after rst is sampled high:
  - State = IDLE; all counters, skew registers, valid bits and accumulators = 0.
  - in_ready, out_valid, out_last, busy, done, cfg_err = 0; out_data = 0; out_row = 0.
  - rst overrides every event in the same cycle, including mid-LOAD and mid-DRAIN.
- A start sampled at edge t gives busy=1 and in_ready=1 from cycle t+1.
- A beat accepted at edge t reaches PE(r,c) and is MACed at edge t+r+c.
- Last beat accepted at edge t → out_valid asserts at cycle t+ROWS+COLS, independent of stalls earlier in LOAD.
- Minimum run time is 1 + k_len + (ROWS+COLS-1) + ROWS cycles to done.
- While out_valid & !out_ready, out_data, out_row and out_last hold stable.
- done and cfg_err are high for exactly one cycle each.
- The cycle after done, a new start is accepted (IDLE).

## Test plan
- Reset: hold rst 2 cycles mid-DRAIN of a prior run → next cycle out_valid=0, busy=0, in_ready=0. A subsequent acc_mode=1 run of identity·identity gives the identity (accumulators were zeroed).
- Identity, 4×4, k_len=4: A=I, B[k][c]=4k+c+1.
  - Rows out are {1,2,3,4}, {5..8}, {9..12}, {13..16}.
  - out_last is set only on row 3; done pulses once.
  - out_valid rises 8 cycles after the last accepted beat.
- Signed, k_len=1: all A=-3, all B=5 → every lane is -15 (sign-extended to 40 bits). Then rerun with acc_mode=1 → -30; rerun with acc_mode=0 → -15.
- Backpressure: repeat the identity test with in_valid toggling 1,0,1,0… and out_ready held low 3 cycles during row 1 → identical results; row 1 data stable throughout the stall.
- Extremes, k_len=2: A=B=-32768 → every lane is 2^31 = 0x0080000000, with no wrap.
- Config errors:
  - start with k_len=0 → one-cycle cfg_err, busy stays 0.
  - start with k_len=257 → cfg_err.
  - start pulsed during LOAD → ignored; the run completes normally.
